// File: rtl/char_locate_ctrl.sv
// Plate window tracker: locks onto a stable plate box across frames, then splits
// its width into CHAR_NUM equal character column slots.
module char_locate_ctrl #(
  parameter int STABLE_FRAMES = 3,
  parameter int TOL           = 2,
  parameter int MIN_W         = 40,
  parameter int MIN_H         = 20,
  parameter int CHAR_NUM      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vs,
  input  logic [11:0] edge_left,
  input  logic [11:0] edge_right,
  input  logic [11:0] edge_up,
  input  logic [11:0] edge_dowm,
  output logic        lock,
  output logic [11:0] win_left,
  output logic [11:0] win_right,
  output logic [11:0] win_up,
  output logic [11:0] win_dowm,
  output logic        char_valid,
  output logic [3:0]  char_idx,
  output logic [11:0] char_x_start,
  output logic [11:0] char_x_end,
  output logic        split_done,
  output logic        busy
);

  localparam int CW = $clog2(STABLE_FRAMES + 1);
  localparam logic [CW-1:0] SF    = CW'(STABLE_FRAMES);
  localparam logic [3:0]    CN    = 4'(CHAR_NUM);
  localparam logic [12:0]   TOL13 = 13'(TOL);
  localparam logic [12:0]   MINW  = 13'(MIN_W);
  localparam logic [12:0]   MINH  = 13'(MIN_H);

  typedef enum logic [1:0] {TRACK, CHECK, DIV, SPLIT} state_t;

  state_t        state_q;
  logic          vs_q;
  logic [CW-1:0] stable_q, stable_d;
  logic [11:0]   cand_l_q, cand_r_q, cand_u_q, cand_d_q;
  logic [11:0]   ref_l_q, ref_r_q, ref_u_q, ref_d_q;
  logic [11:0]   ref_l_d, ref_r_d, ref_u_d, ref_d_d;
  logic [11:0]   dvd_q, step_q, pos_q;
  logic [3:0]    rem_q, div_cnt_q, slot_q;
  logic [4:0]    rem_sh, rem_nx;
  logic [12:0]   w13, h13;
  logic          fe, cand_ok, match, div_ge;

  function automatic logic near(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] d;
    d = (a >= b) ? a - b : b - a;
    return {1'b0, d} <= TOL13;
  endfunction

  always_comb begin
    fe      = vs_q & ~i_vs;
    w13     = {1'b0, cand_r_q} - {1'b0, cand_l_q};
    h13     = {1'b0, cand_d_q} - {1'b0, cand_u_q};
    cand_ok = (cand_r_q > cand_l_q) && (cand_d_q > cand_u_q) && (w13 >= MINW) && (h13 >= MINH);
    match   = (stable_q != '0) && near(cand_l_q, ref_l_q) && near(cand_r_q, ref_r_q) &&
              near(cand_u_q, ref_u_q) && near(cand_d_q, ref_d_q);
    stable_d = match ? ((stable_q == SF) ? SF : stable_q + CW'(1)) : CW'(1);
    ref_l_d  = match ? ref_l_q : cand_l_q;
    ref_r_d  = match ? ref_r_q : cand_r_q;
    ref_u_d  = match ? ref_u_q : cand_u_q;
    ref_d_d  = match ? ref_d_q : cand_d_q;
    // restoring divider: quotient bits shift into dvd_q as the dividend shifts out
    rem_sh   = {rem_q, dvd_q[11]};
    div_ge   = rem_sh >= {1'b0, CN};
    rem_nx   = div_ge ? rem_sh - {1'b0, CN} : rem_sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= TRACK;
      vs_q         <= 1'b1;
      stable_q     <= '0;
      cand_l_q     <= '0; cand_r_q <= '0; cand_u_q <= '0; cand_d_q <= '0;
      ref_l_q      <= '0; ref_r_q  <= '0; ref_u_q  <= '0; ref_d_q  <= '0;
      dvd_q        <= '0; step_q   <= '0; pos_q    <= '0;
      rem_q        <= '0; div_cnt_q <= '0; slot_q  <= '0;
      lock         <= 1'b0;
      win_left     <= '0; win_right <= '0; win_up <= '0; win_dowm <= '0;
      char_valid   <= 1'b0;
      char_idx     <= '0;
      char_x_start <= '0;
      char_x_end   <= '0;
      split_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      vs_q       <= i_vs;
      char_valid <= 1'b0;
      split_done <= 1'b0;
      case (state_q)
        TRACK: if (fe) begin
          cand_l_q <= edge_left;  cand_r_q <= edge_right;
          cand_u_q <= edge_up;    cand_d_q <= edge_dowm;
          state_q  <= CHECK;
        end
        CHECK: begin
          if (!cand_ok) begin
            stable_q <= '0;
            lock     <= 1'b0;
            state_q  <= TRACK;
          end else begin
            stable_q <= stable_d;
            ref_l_q  <= ref_l_d; ref_r_q <= ref_r_d;
            ref_u_q  <= ref_u_d; ref_d_q <= ref_d_d;
            if (!match) lock <= 1'b0;
            if (stable_d == SF) begin
              lock      <= 1'b1;
              win_left  <= ref_l_d; win_right <= ref_r_d;
              win_up    <= ref_u_d; win_dowm  <= ref_d_d;
              dvd_q     <= ref_r_d - ref_l_d;
              rem_q     <= '0;
              div_cnt_q <= '0;
              busy      <= 1'b1;
              state_q   <= DIV;
            end else begin
              state_q <= TRACK;
            end
          end
        end
        DIV: begin
          rem_q     <= rem_nx[3:0];
          dvd_q     <= {dvd_q[10:0], div_ge};
          div_cnt_q <= div_cnt_q + 4'd1;
          if (div_cnt_q == 4'd11) begin
            step_q  <= {dvd_q[10:0], div_ge};
            pos_q   <= win_left;
            slot_q  <= '0;
            state_q <= SPLIT;
          end
        end
        SPLIT: begin
          if (slot_q != CN) begin
            char_valid   <= 1'b1;
            char_idx     <= slot_q;
            char_x_start <= pos_q;
            char_x_end   <= pos_q + step_q - 12'd1;
            pos_q        <= pos_q + step_q;
            slot_q       <= slot_q + 4'd1;
          end else begin
            split_done <= 1'b1;
            busy       <= 1'b0;
            state_q    <= TRACK;
          end
        end
        default: state_q <= TRACK;
      endcase
    end
  end

endmodule

// File: tb/tb_char_locate_ctrl.sv
// Directed bench for char_locate_ctrl: lock acquisition, tolerance, invalid frames,
// slot generation, ignored frame ends while busy and reset abort.
module tb_char_locate_ctrl;
  logic        clk = 0, rst = 1, i_vs = 1;
  logic [11:0] edge_left = 0, edge_right = 0, edge_up = 0, edge_dowm = 0;
  logic        lock, char_valid, split_done, busy;
  logic [11:0] win_left, win_right, win_up, win_dowm, char_x_start, char_x_end;
  logic [3:0]  char_idx;
  int          errors = 0, checks = 0, sd_cnt = 0, sd_ref;

  char_locate_ctrl dut (
    .clk(clk), .rst(rst), .i_vs(i_vs),
    .edge_left(edge_left), .edge_right(edge_right), .edge_up(edge_up), .edge_dowm(edge_dowm),
    .lock(lock), .win_left(win_left), .win_right(win_right), .win_up(win_up), .win_dowm(win_dowm),
    .char_valid(char_valid), .char_idx(char_idx), .char_x_start(char_x_start),
    .char_x_end(char_x_end), .split_done(split_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (split_done) sd_cnt <= sd_cnt + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one frame: vs high then low; returns #1 after the CHECK-state edge
  task automatic do_frame(input int l, input int r, input int u, input int d);
    @(negedge clk);
    edge_left = 12'(l); edge_right = 12'(r); edge_up = 12'(u); edge_dowm = 12'(d);
    i_vs = 1;
    @(negedge clk);
    i_vs = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic collect(input int left, input int step, input bit inject);
    bit seen = 0;
    int base = sd_cnt;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk); #1;
      seen = char_valid;
    end
    chk("slots_start", int'(seen), 1);
    for (int i = 0; i < 7; i++) begin
      chk("slot_valid", int'(char_valid), 1);
      chk("slot_idx", int'(char_idx), i);
      chk("slot_xs", int'(char_x_start), left + i * step);
      chk("slot_xe", int'(char_x_end), left + i * step + step - 1);
      if (inject && i == 1) begin i_vs = 1; edge_left = 300; edge_right = 280; end
      if (inject && i == 3) i_vs = 0;
      @(posedge clk); #1;
    end
    chk("after_valid", int'(char_valid), 0);
    chk("done_pulse", int'(split_done), 1);
    chk("busy_clear", int'(busy), 0);
    @(posedge clk); #1;
    chk("done_single", int'(split_done), 0);
    chk("xs_hold", int'(char_x_start), left + 6 * step);
    chk("done_count", sd_cnt - base, 1);
  endtask

  initial begin
    idle(3);
    chk("rst_lock", int'(lock), 0);
    chk("rst_valid", int'(char_valid), 0);
    chk("rst_win_l", int'(win_left), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(split_done), 0);
    chk("rst_xs", int'(char_x_start), 0);
    @(negedge clk); rst = 0;

    // tolerance-matching frames lock onto the first frame's box
    do_frame(100, 380, 80, 160); chk("f1_lock", int'(lock), 0);
    do_frame(101, 379, 81, 159); chk("f2_lock", int'(lock), 0);
    do_frame(102, 378, 82, 158);
    chk("f3_lock", int'(lock), 1);
    chk("f3_busy", int'(busy), 1);
    chk("win_l", int'(win_left), 100);
    chk("win_r", int'(win_right), 380);
    chk("win_u", int'(win_up), 80);
    chk("win_d", int'(win_dowm), 160);
    collect(100, 40, 0);

    // re-run while locked, with a frame end arriving mid-split
    do_frame(100, 380, 80, 160);
    chk("rerun_lock", int'(lock), 1);
    chk("rerun_cnt", int'(dut.stable_q), 3);
    collect(100, 40, 1);
    idle(3);
    chk("inject_lock", int'(lock), 1);
    chk("inject_busy", int'(busy), 0);

    // invalid box drops lock, window holds
    do_frame(300, 280, 80, 160);
    chk("bad_lock", int'(lock), 0);
    chk("bad_cnt", int'(dut.stable_q), 0);
    chk("bad_win_l", int'(win_left), 100);
    chk("bad_win_r", int'(win_right), 380);
    chk("bad_busy", int'(busy), 0);

    // out-of-tolerance frame restarts the count from the new box
    do_frame(100, 380, 80, 160);
    do_frame(100, 380, 80, 160);
    do_frame(106, 380, 80, 160);
    chk("jump_lock", int'(lock), 0);
    chk("jump_cnt", int'(dut.stable_q), 1);
    chk("jump_ref", int'(dut.ref_l_q), 106);
    do_frame(106, 380, 80, 160); chk("j2_lock", int'(lock), 0);
    do_frame(106, 380, 80, 160); chk("j3_lock", int'(lock), 1);
    chk("j3_win_l", int'(win_left), 106);
    collect(106, 39, 0);

    // reset while slot 3 is on the outputs
    do_frame(106, 380, 80, 160);
    begin
      bit at3 = 0;
      for (int n = 0; n < 40 && !at3; n++) begin
        @(posedge clk); #1;
        at3 = char_valid && (char_idx == 4'd3);
      end
      chk("reach_slot3", int'(at3), 1);
    end
    sd_ref = sd_cnt;
    rst = 1; i_vs = 1;
    @(posedge clk); #1;
    chk("abort_valid", int'(char_valid), 0);
    chk("abort_lock", int'(lock), 0);
    chk("abort_idx", int'(char_idx), 0);
    chk("abort_xs", int'(char_x_start), 0);
    chk("abort_xe", int'(char_x_end), 0);
    chk("abort_win_l", int'(win_left), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(split_done), 0);
    @(negedge clk); rst = 0;
    idle(30);
    chk("abort_no_done", sd_cnt - sd_ref, 0);
    chk("abort_idle_valid", int'(char_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/char_locate_ctrl.md
CHAR_LOCATE_CTRL -- requirements
Module: char_locate_ctrl

Interface
REQ-001 Parameter STABLE_FRAMES, default 3: consecutive matching frames required to lock.
REQ-002 Parameter TOL, default 2: max per-edge deviation (pixels) counted as a match.
REQ-003 Parameter MIN_W, default 40: minimum plate width (right-left).
REQ-004 Parameter MIN_H, default 20: minimum plate height (dowm-up).
REQ-005 Parameter CHAR_NUM, default 7: character slots per plate, range 2..15.
REQ-006 clk  in  1  sole clock, all logic on rising edge.
REQ-007 rst  in  1  one clock; reset is synchronous and active-high.
REQ-008 i_vs  in  1  frame sync; 1->0 transition marks frame end and edge results valid.
REQ-009 edge_left, edge_right, edge_up, edge_dowm  in  12 each  per-frame plate edge estimates.
REQ-010 lock  out  1  plate window stable and published.
REQ-011 win_left, win_right, win_up, win_dowm  out  12 each  locked window.
REQ-012 char_valid  out  1  one slot emitted this cycle.
REQ-013 char_idx  out  4  slot index 0..CHAR_NUM-1.
REQ-014 char_x_start, char_x_end  out  12 each  slot column bounds, inclusive.
REQ-015 split_done  out  1  single-cycle pulse after last slot.
REQ-016 busy  out  1  high in DIV and SPLIT.

Function
REQ-017 Frame end fe SHALL be vs_d AND NOT i_vs, vs_d being i_vs registered (reset value 1).
REQ-018 States SHALL be TRACK, CHECK, DIV, SPLIT; reset state TRACK.
REQ-019 TRACK: on fe, latch all four edges into candidate registers, go CHECK next cycle.
REQ-020 CHECK (one cycle): candidate valid iff right>left, dowm>up, right-left>=MIN_W, dowm-up>=MIN_H; differences in 13-bit unsigned.
REQ-021 Invalid candidate: stable_cnt<=0, lock<=0, go TRACK.
REQ-022 Valid and every |cand-ref|<=TOL: stable_cnt increments, saturating at STABLE_FRAMES; ref unchanged.
REQ-023 Valid but any |cand-ref|>TOL, or stable_cnt==0: ref<=cand, stable_cnt<=1, lock<=0.
REQ-024 If stable_cnt after update equals STABLE_FRAMES: lock<=1, win_*<=ref, go DIV; else go TRACK.
REQ-025 lock SHALL be visible at the second rising edge after the edge at which fe is sampled true.
REQ-026 DIV: 12-cycle restoring division step=(win_right-win_left)/CHAR_NUM, remainder discarded; then SPLIT.
REQ-027 SPLIT: CHAR_NUM consecutive cycles with char_valid=1, char_idx=i, char_x_start=win_left+i*step, char_x_end=char_x_start+step-1 (running adder, no multiplier).
REQ-028 Cycle after last slot: split_done=1, char_valid=0, go TRACK.
REQ-029 fe during CHECK, DIV or SPLIT SHALL be ignored (no latch, no count change).
REQ-030 Once locked, every subsequent valid matching frame SHALL re-run DIV/SPLIT; a failing frame clears lock, win_* hold last values.
REQ-031 char_idx, char_x_* SHALL hold last values when char_valid=0.

Reset
REQ-032 On rst: state TRACK, vs_d=1, stable_cnt=0, ref/cand=0, lock=0, win_*=0, char_valid=0, char_idx=0, char_x_*=0, split_done=0, busy=0.
REQ-033 rst asserted mid-DIV or mid-SPLIT SHALL abort: char_valid=0 at next edge, no split_done.

Verification
REQ-034 Three frames of edges (100,380,80,160) -> lock=1 after 3rd fe; step=40; slots start 100,140,...,340, end 139,...,379; split_done once.
REQ-035 Frames (100,380,80,160),(101,379,81,159),(102,378,82,158) -> all match, lock=1, win=(100,380,80,160).
REQ-036 Two matching frames then (106,380,80,160) -> stable_cnt=1, ref=(106,...), lock stays 0.
REQ-037 Locked, then frame (300,280,80,160) -> lock=0, stable_cnt=0, win_* unchanged.
REQ-038 fe pulse during SPLIT -> ignored, slot sequence and count unaffected; rst at slot 3 -> char_valid=0 next cycle, all outputs at reset values.
